// File: rtl/key_event_unit.sv
// Push-button front end: 2-flop synchronizer, per-key debounce, sticky W1C
// press/release events with maskable level interrupt, small Avalon-MM slave.
module key_event_unit #(
  parameter int unsigned NKEYS           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [NKEYS-1:0] key_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic [NKEYS-1:0] key_level,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NKEYS-1:0] sync1, sync2;
  logic [NKEYS-1:0] stable, stable_nxt;
  logic [CNT_W-1:0] cnt [NKEYS];
  logic [NKEYS-1:0] accept;
  logic [NKEYS-1:0] press_evt, rel_evt, press_mask, rel_mask;
  logic [NKEYS-1:0] press_set, rel_set, press_clr, rel_clr;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign unused_wdata = ^avs_writedata;

  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
    end
  end

  // key_level and the event bits are updated on the same edge as stable,
  // so edges are detected against the next-state value.
  assign stable_nxt = (stable & ~accept) | (sync2 & accept);
  assign press_set  = stable & ~stable_nxt;
  assign rel_set    = ~stable & stable_nxt;

  always_comb begin
    press_clr = '0;
    rel_clr   = '0;
    if (avs_write && avs_address == 2'd1) begin
      press_clr = avs_writedata[NKEYS-1:0];
      rel_clr   = avs_writedata[16 +: NKEYS];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      2'd0: rd_mux[NKEYS-1:0] = key_level;
      2'd1: begin
        rd_mux[NKEYS-1:0]  = press_evt;
        rd_mux[16 +: NKEYS] = rel_evt;
      end
      2'd2: begin
        rd_mux[NKEYS-1:0]  = press_mask;
        rd_mux[16 +: NKEYS] = rel_mask;
      end
      default: rd_mux[NKEYS-1:0] = sync2;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync1        <= '1;
      sync2        <= '1;
      stable       <= '1;
      key_level    <= '0;
      press_evt    <= '0;
      rel_evt      <= '0;
      press_mask   <= '0;
      rel_mask     <= '0;
      avs_readdata <= '0;
      for (int unsigned i = 0; i < NKEYS; i++) cnt[i] <= '0;
    end else begin
      sync1     <= key_in;
      sync2     <= sync1;
      stable    <= stable_nxt;
      key_level <= ~stable_nxt;
      for (int unsigned i = 0; i < NKEYS; i++) begin
        if (sync2[i] == stable[i] || accept[i]) cnt[i] <= '0;
        else                                     cnt[i] <= cnt[i] + 1'b1;
      end
      // set has priority over a coincident W1C
      press_evt <= (press_evt & ~press_clr) | press_set;
      rel_evt   <= (rel_evt & ~rel_clr) | rel_set;
      if (avs_write && avs_address == 2'd2) begin
        press_mask <= avs_writedata[NKEYS-1:0];
        rel_mask   <= avs_writedata[16 +: NKEYS];
      end
      avs_readdata <= avs_read ? rd_mux : '0;
    end
  end

  assign irq = (|(press_evt & press_mask)) | (|(rel_evt & rel_mask));

endmodule
